// File: rtl/game_pkg.sv
// Shared definitions for the duck-hunt game flow controller.
//   state_e            : top-level game FSM states
//   DEF_DUCKS_PER_GAME : default ducks launched per game
//   DEF_MAG_SIZE       : default bullets loaded per duck
//   SCORE_MAX          : score saturation value
//   FRAME_CNT_W        : width of the shared frame counter
package game_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_SPAWN,
        S_FLY,
        S_FALL,
        S_END
    } state_e;

    localparam int unsigned DEF_DUCKS_PER_GAME = 10;
    localparam int unsigned DEF_MAG_SIZE       = 3;
    localparam logic [6:0]  SCORE_MAX          = 7'd99;
    localparam int unsigned FRAME_CNT_W        = 16;

endpackage

// File: rtl/click_edge_det.sv
// Rising-edge detector for the (already synchronised) mouse button.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   level : button level
//   pulse : high for the one cycle where level is 1 and was 0 on the previous cycle
module click_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/game_flow_ctl.sv
// Game flow controller: start screen -> ducks (spawn/fly/fall) -> end screen.
//   clk, rst_n          : pixel clock, synchronous active-low reset
//   frame_tick          : one pulse per frame
//   mouse_left          : left button level (synchronised)
//   target_hit          : cursor over duck, used only on a shot
//   start_screen_enable : start stage active
//   game_enable         : spawn/fly/fall stage active
//   game_end_enable     : end stage active
//   duck_spawn          : one-cycle launch pulse for the duck controller
//   duck_killed         : high during the fall animation
//   bullets_in_magazine : bullets left for the current duck
//   score               : ducks killed this game (saturating)
//   ducks_left          : ducks still to launch, including the current one
// All outputs are registered.
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int unsigned DUCKS_PER_GAME     = DEF_DUCKS_PER_GAME,
    parameter int unsigned MAG_SIZE           = DEF_MAG_SIZE,
    parameter int unsigned FLY_TIMEOUT_FRAMES = 300,
    parameter int unsigned FALL_FRAMES        = 60,
    parameter int unsigned END_HOLD_FRAMES    = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       mouse_left,
    input  logic       target_hit,
    output logic       start_screen_enable,
    output logic       game_enable,
    output logic       game_end_enable,
    output logic       duck_spawn,
    output logic       duck_killed,
    output logic [2:0] bullets_in_magazine,
    output logic [6:0] score,
    output logic [3:0] ducks_left
);

    localparam logic [FRAME_CNT_W-1:0] FLY_LAST  = FRAME_CNT_W'(FLY_TIMEOUT_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] FALL_LAST = FRAME_CNT_W'(FALL_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] END_HOLD  = FRAME_CNT_W'(END_HOLD_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);

    state_e                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic [2:0]             bullets_d;
    logic [6:0]             score_d;
    logic [3:0]             ducks_d;
    logic                   spawn_d;
    logic                   kill;
    logic                   duck_done;
    logic                   click;

    click_edge_det u_click (
        .clk   (clk),
        .rst_n (rst_n),
        .level (mouse_left),
        .pulse (click)
    );

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        bullets_d = bullets_in_magazine;
        score_d   = score;
        ducks_d   = ducks_left;
        spawn_d   = 1'b0;
        kill      = 1'b0;
        duck_done = 1'b0;

        unique case (state_q)
            S_START: begin
                if (click) begin
                    score_d = 7'd0;
                    ducks_d = 4'(DUCKS_PER_GAME);
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN: begin
                spawn_d   = 1'b1;
                bullets_d = 3'(MAG_SIZE);
                fcnt_d    = '0;
                state_d   = S_FLY;
            end
            S_FLY: begin
                if (frame_tick) begin
                    fcnt_d = fcnt_q + CNT_ONE;
                end
                if (click && bullets_in_magazine != 3'd0) begin
                    bullets_d = bullets_in_magazine - 3'd1;
                    if (target_hit) begin
                        kill    = 1'b1;
                        score_d = (score >= SCORE_MAX) ? SCORE_MAX : score + 7'd1;
                        fcnt_d  = '0;
                        state_d = S_FALL;
                    end else if (bullets_in_magazine == 3'd1) begin
                        duck_done = 1'b1;
                    end
                end
                // A kill on the timeout frame wins over the escape.
                if (!kill && frame_tick && fcnt_q == FLY_LAST) begin
                    duck_done = 1'b1;
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    if (fcnt_q == FALL_LAST) begin
                        duck_done = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + CNT_ONE;
                    end
                end
            end
            S_END: begin
                // Counter saturates at the hold length; clicks only count after it.
                if (fcnt_q < END_HOLD) begin
                    if (frame_tick) begin
                        fcnt_d = fcnt_q + CNT_ONE;
                    end
                end else if (click) begin
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase

        // Current duck is finished (escaped or fall animation over).
        if (duck_done) begin
            ducks_d = ducks_left - 4'd1;
            fcnt_d  = '0;
            state_d = (ducks_left > 4'd1) ? S_SPAWN : S_END;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= S_START;
            fcnt_q              <= '0;
            start_screen_enable <= 1'b1;
            game_enable         <= 1'b0;
            game_end_enable     <= 1'b0;
            duck_spawn          <= 1'b0;
            duck_killed         <= 1'b0;
            bullets_in_magazine <= 3'd0;
            score               <= 7'd0;
            ducks_left          <= 4'd0;
        end else begin
            state_q             <= state_d;
            fcnt_q              <= fcnt_d;
            start_screen_enable <= (state_d == S_START);
            game_enable         <= (state_d == S_SPAWN) || (state_d == S_FLY)
                                   || (state_d == S_FALL);
            game_end_enable     <= (state_d == S_END);
            duck_spawn          <= spawn_d;
            duck_killed         <= (state_d == S_FALL);
            bullets_in_magazine <= bullets_d;
            score               <= score_d;
            ducks_left          <= ducks_d;
        end
    end

endmodule

// File: tb/tb_game_flow_ctl.sv
`timescale 1ns/1ps
// Directed bench for game_flow_ctl at default parameters.
module tb_game_flow_ctl;

    typedef struct packed {
        logic       st;
        logic       gm;
        logic       en;
        logic       sp;
        logic       k;
        logic [2:0] bul;
        logic [6:0] sc;
        logic [3:0] dl;
    } out_t;

    typedef struct {
        logic r;
        logic t;
        logic m;
        logic h;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       mouse_left = 1'b0;
    logic       target_hit = 1'b0;
    logic       start_screen_enable;
    logic       game_enable;
    logic       game_end_enable;
    logic       duck_spawn;
    logic       duck_killed;
    logic [2:0] bullets_in_magazine;
    logic [6:0] score;
    logic [3:0] ducks_left;

    int n_vec  = 0;
    int n_miss = 0;

    game_flow_ctl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frame_tick          (frame_tick),
        .mouse_left          (mouse_left),
        .target_hit          (target_hit),
        .start_screen_enable (start_screen_enable),
        .game_enable         (game_enable),
        .game_end_enable     (game_end_enable),
        .duck_spawn          (duck_spawn),
        .duck_killed         (duck_killed),
        .bullets_in_magazine (bullets_in_magazine),
        .score               (score),
        .ducks_left          (ducks_left)
    );

    always #5 clk = ~clk;

    function automatic out_t o(bit st, bit gm, bit en, bit sp, bit k, int bul, int sc, int dl);
        out_t r;
        r.st  = st;
        r.gm  = gm;
        r.en  = en;
        r.sp  = sp;
        r.k   = k;
        r.bul = 3'(bul);
        r.sc  = 7'(sc);
        r.dl  = 4'(dl);
        return r;
    endfunction

    // Apply inputs for one clock edge; outputs are sampled 1 ns after it.
    task automatic drive(input logic r, input logic t, input logic m, input logic h);
        rst_n      = r;
        frame_tick = t;
        mouse_left = m;
        target_hit = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = {start_screen_enable, game_enable, game_end_enable, duck_spawn, duck_killed,
               bullets_in_magazine, score, ducks_left};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got st=%b gm=%b en=%b sp=%b k=%b bul=%0d sc=%0d dl=%0d, want st=%b gm=%b en=%b sp=%b k=%b bul=%0d sc=%0d dl=%0d",
                     name, act.st, act.gm, act.en, act.sp, act.k, act.bul, act.sc, act.dl,
                     exp.st, exp.gm, exp.en, exp.sp, exp.k, exp.bul, exp.sc, exp.dl);
        end
    endtask

    // n frame ticks, each followed by an idle cycle, no clicks.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        //           rst   tick  ml    hit      st gm en sp k bul sc dl
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, o(0, 1, 0, 0, 0, 0, 0, 10)};  // start click
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, o(0, 1, 0, 1, 0, 3, 0, 10)};  // spawn pulse
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, o(0, 1, 0, 0, 0, 3, 0, 10)};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, o(0, 1, 0, 0, 1, 2, 1, 10)};  // kill
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, o(0, 1, 0, 0, 1, 2, 1, 10)};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, o(0, 1, 0, 0, 1, 2, 1, 10)};  // click while falling
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, o(0, 1, 0, 0, 1, 2, 1, 10)};  // fall tick 1

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r, tbl[i].t, tbl[i].m, tbl[i].h);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Fall lasts 60 ticks: tick 60 ends it.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(58);
        check("fall_tick59", o(0, 1, 0, 0, 1, 2, 1, 10));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("fall_done", o(0, 1, 0, 0, 0, 2, 1, 9));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("respawn_after_kill", o(0, 1, 0, 1, 0, 3, 1, 9));

        // Three misses empty the magazine and the duck escapes.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("miss1", o(0, 1, 0, 0, 0, 2, 1, 9));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("miss2", o(0, 1, 0, 0, 0, 1, 1, 9));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("miss3_escape", o(0, 1, 0, 0, 0, 0, 1, 8));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("respawn_after_miss", o(0, 1, 0, 1, 0, 3, 1, 8));

        // Timeout on the 300th tick.
        ticks(299);
        check("fly_tick299", o(0, 1, 0, 0, 0, 3, 1, 8));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("timeout_escape", o(0, 1, 0, 0, 0, 3, 1, 7));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("respawn_after_timeout", o(0, 1, 0, 1, 0, 3, 1, 7));

        // Score pinned at 99, then a kill on the timeout tick: kill wins, score saturates.
        ticks(299);
        force dut.score = 7'd99;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        release dut.score;
        check("score_forced", o(0, 1, 0, 0, 0, 3, 99, 7));
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("kill_beats_timeout_sat", o(0, 1, 0, 0, 1, 2, 99, 7));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("falling_99", o(0, 1, 0, 0, 1, 2, 99, 7));

        // Reset during the fall aborts immediately with no spawn.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_in_fall", o(1, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("after_reset_idle", o(1, 0, 0, 0, 0, 0, 0, 0));

        // New game, ten timeouts.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("game2_start", o(0, 1, 0, 0, 0, 0, 0, 10));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("game2_spawn", o(0, 1, 0, 1, 0, 3, 0, 10));
        for (int d = 10; d >= 1; d--) begin
            ticks(299);
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            if (d > 1) begin
                check($sformatf("escape_d%0d", d), o(0, 1, 0, 0, 0, 3, 0, d - 1));
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                check($sformatf("spawn_d%0d", d - 1), o(0, 1, 0, 1, 0, 3, 0, d - 1));
            end else begin
                check("game_end", o(0, 0, 1, 0, 0, 3, 0, 0));
            end
        end

        // End hold: clicks at tick 50 and tick 119 ignored, accepted after tick 120.
        ticks(50);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("end_click_f50", o(0, 0, 1, 0, 0, 3, 0, 0));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(69);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("end_click_f119", o(0, 0, 1, 0, 0, 3, 0, 0));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("end_tick120", o(0, 0, 1, 0, 0, 3, 0, 0));
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("end_to_start", o(1, 0, 0, 0, 0, 3, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_flow_ctl.md
GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

Interface
REQ-001 The module SHALL have parameter DUCKS_PER_GAME, default 10, the number of ducks per game (1..15).
REQ-002 The module SHALL have parameter MAG_SIZE, default 3, the bullets loaded per duck (1..7).
REQ-003 The module SHALL have parameter FLY_TIMEOUT_FRAMES, default 300, the frames a duck flies before it escapes.
REQ-004 The module SHALL have parameter FALL_FRAMES, default 60, the frames of the kill/fall animation.
REQ-005 The module SHALL have parameter END_HOLD_FRAMES, default 120, the frames the end screen ignores clicks.
REQ-006 Port clk, input, 1, 65 MHz pixel clock; every register is on its rising edge.
REQ-007 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-008 Port frame_tick, input, 1, one-cycle pulse once per frame, from vsync.
REQ-009 Port mouse_left, input, 1, left button level, already synchronised to clk.
REQ-010 Port target_hit, input, 1, cursor is over the duck; sampled only in the shot cycle.
REQ-011 Port start_screen_enable, output, 1, start-screen stage active.
REQ-012 Port game_enable, output, 1, game stage active.
REQ-013 Port game_end_enable, output, 1, end-screen stage active.
REQ-014 Port duck_spawn, output, 1, one-cycle pulse that tells duck_ctl to launch a new duck.
REQ-015 Port duck_killed, output, 1, high for the whole fall animation.
REQ-016 Port bullets_in_magazine, output, 3, bullets remaining for the current duck.
REQ-017 Port score, output, 7, ducks killed in this game.
REQ-018 Port ducks_left, output, 4, ducks still to be launched, including the current one.

Function
REQ-019 The FSM SHALL have states S_START, S_SPAWN, S_FLY, S_FALL, S_END; S_SPAWN lasts exactly 1 cycle.
REQ-020 A click SHALL be a rising edge of mouse_left, detected internally (previous-value register).
REQ-021 Stage enables SHALL be registered and one-hot: S_START gives start_screen_enable; S_SPAWN/S_FLY/S_FALL give game_enable; S_END gives game_end_enable.
REQ-022 In S_START, a click SHALL load score=0, ducks_left=DUCKS_PER_GAME and go to S_SPAWN.
REQ-023 In S_SPAWN, duck_spawn SHALL pulse, bullets_in_magazine SHALL load MAG_SIZE, the frame counter SHALL clear and the FSM SHALL go to S_FLY.
REQ-024 In S_FLY, a click with bullets_in_magazine>0 SHALL be a shot and SHALL decrement bullets_in_magazine by 1 in the next cycle.
REQ-025 A click with bullets_in_magazine=0 SHALL be ignored.
REQ-026 A shot with target_hit=1 SHALL increment score, saturating at 99, and SHALL go to S_FALL with duck_killed=1; the kill takes priority over a timeout in the same cycle.
REQ-027 A miss that leaves 0 bullets, or the frame counter reaching FLY_TIMEOUT_FRAMES, SHALL be an escape: decrement ducks_left, then go to S_SPAWN if the result is >0, else S_END.
REQ-028 In S_FLY the frame counter SHALL count frame_tick pulses only.
REQ-029 In S_FALL the FSM SHALL count FALL_FRAMES frame_ticks.
REQ-030 When the S_FALL count completes, duck_killed SHALL drop, ducks_left SHALL decrement, and the next state SHALL follow the REQ-027 rule.
REQ-031 Clicks in S_FALL SHALL be ignored.
REQ-032 In S_END, clicks SHALL be ignored until END_HOLD_FRAMES frame_ticks have elapsed.
REQ-033 After the hold, a click in S_END SHALL go to S_START; score SHALL be held until the next game starts.
REQ-034 All outputs SHALL be registered, with a 1-cycle latency from a triggering input to the output.

Reset
REQ-035 With rst_n=0 at a clk edge, the FSM SHALL go to S_START; start_screen_enable=1, other enables 0, duck_spawn=0, duck_killed=0, bullets_in_magazine=0, score=0, ducks_left=0, counters and edge register 0.
REQ-036 Reset mid-game SHALL abort immediately with the same values, and no duck_spawn SHALL be emitted.

Structure
REQ-037 game_pkg SHALL hold the state enum, the MAG_SIZE and DUCKS_PER_GAME defaults and SCORE_MAX=99.
REQ-038 One sub-module, click_edge_det (clk, rst_n, level in, one-cycle pulse out), SHALL be used; the rest is a single always_ff FSM plus counters.

Verification
REQ-039 Reset then click -> start_screen_enable 1→0, game_enable=1, duck_spawn pulse, bullets_in_magazine=3, ducks_left=10.
REQ-040 In S_FLY, click with target_hit=1 -> bullets=2, score=1, duck_killed=1 for 60 frame_ticks, then ducks_left=9 and a new duck_spawn.
REQ-041 Three clicks with target_hit=0 -> bullets 3→2→1→0, escape, ducks_left=9, spawn; a 4th click before the spawn changes nothing.
REQ-042 No clicks for 300 frame_ticks -> escape; after 10 escapes -> game_end_enable=1, score=0; a click at frame 50 is ignored, a click after 120 frames -> start_screen_enable=1.
REQ-043 Force score to 99, then a kill -> score stays 99.
REQ-044 rst_n=0 during S_FALL -> next cycle start_screen_enable=1, duck_killed=0, score=0.
